// File: rtl/mips_run_ctrl.sv
// Run/step/clear execution controller for the mips core: conditions raw push-buttons,
// sequences run-enable and PC-clear, halts free-run on an optional PC breakpoint.
module mips_run_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CLR_CYCLES      = 4
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        btn_step_i,
  input  logic        btn_run_i,
  input  logic        btn_clr_i,
  input  logic        bp_en_i,
  input  logic [31:0] bp_addr_i,
  input  logic [31:0] pc_i,
  output logic        pc_run_en_o,
  output logic        pc_clr_o,
  output logic [1:0]  state_o,
  output logic        bp_hit_o,
  output logic [15:0] instr_cnt_o
);

  localparam int unsigned NumBtn = 3;
  localparam int unsigned DbW    = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned ClrW   = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [DbW-1:0]  DbMax  = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [ClrW-1:0] ClrMax = ClrW'(CLR_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StStep  = 2'b10,
    StClear = 2'b11
  } state_e;

  // Button index: 0 = step, 1 = run, 2 = clr.
  logic [NumBtn-1:0] btn_raw;
  logic [NumBtn-1:0] sync1_q, sync2_q;
  logic [NumBtn-1:0] stable_q, stable_d, stable_prev_q;
  logic [DbW-1:0]    db_cnt_q [NumBtn];
  logic [DbW-1:0]    db_cnt_d [NumBtn];
  logic [NumBtn-1:0] press;

  assign btn_raw = {btn_clr_i, btn_run_i, btn_step_i};

  always_comb begin
    for (int i = 0; i < NumBtn; i++) begin
      stable_d[i] = stable_q[i];
      db_cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DbMax) begin
          stable_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      for (int i = 0; i < NumBtn; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q       <= btn_raw;
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      for (int i = 0; i < NumBtn; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  assign press = stable_q & ~stable_prev_q;

  logic step_press, run_press, clr_press;
  assign step_press = press[0];
  assign run_press  = press[1];
  assign clr_press  = press[2];

  state_e            state_q, state_d;
  logic              skip_bp_q, skip_bp_d;
  logic              bp_hit_q, bp_hit_d;
  logic [ClrW-1:0]   clr_cnt_q, clr_cnt_d;
  logic [15:0]       instr_cnt_q, instr_cnt_d;
  logic              bp_match;
  logic              run_en;
  logic              clr_en;

  // skip_bp lets a resumed run execute the instruction it halted on.
  assign bp_match = bp_en_i && (pc_i == bp_addr_i) && !skip_bp_q;

  always_comb begin
    state_d   = state_q;
    skip_bp_d = skip_bp_q;
    bp_hit_d  = bp_hit_q;
    clr_cnt_d = clr_cnt_q;
    run_en    = 1'b0;
    clr_en    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (clr_press) begin
          state_d   = StClear;
          clr_cnt_d = '0;
          bp_hit_d  = 1'b0;
        end else if (run_press) begin
          state_d   = StRun;
          skip_bp_d = 1'b1;
          bp_hit_d  = 1'b0;
        end else if (step_press) begin
          state_d = StStep;
        end
      end
      StStep: begin
        run_en  = 1'b1;
        state_d = StIdle;
      end
      StRun: begin
        run_en    = !bp_match;
        skip_bp_d = 1'b0;
        if (clr_press) begin
          state_d   = StClear;
          clr_cnt_d = '0;
          bp_hit_d  = 1'b0;
        end else if (bp_match) begin
          state_d  = StIdle;
          bp_hit_d = 1'b1;
        end else if (run_press) begin
          state_d = StIdle;
        end
      end
      StClear: begin
        clr_en = 1'b1;
        if (clr_cnt_q == ClrMax) begin
          state_d = StIdle;
        end else begin
          clr_cnt_d = clr_cnt_q + ClrW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Entering CLEAR wins over a run-enabled cycle in the same clock.
  always_comb begin
    instr_cnt_d = instr_cnt_q;
    if ((state_d == StClear) && (state_q != StClear)) begin
      instr_cnt_d = '0;
    end else if (run_en) begin
      instr_cnt_d = instr_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      skip_bp_q   <= 1'b0;
      bp_hit_q    <= 1'b0;
      clr_cnt_q   <= '0;
      instr_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      skip_bp_q   <= skip_bp_d;
      bp_hit_q    <= bp_hit_d;
      clr_cnt_q   <= clr_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign pc_run_en_o = run_en;
  assign pc_clr_o    = clr_en;
  assign state_o     = state_q;
  assign bp_hit_o    = bp_hit_q;
  assign instr_cnt_o = instr_cnt_q;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Directed bench for mips_run_ctrl with a small PC model standing in for the core.
module tb_mips_run_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_step = 1'b0, btn_run = 1'b0, btn_clr = 1'b0;
  logic        bp_en = 1'b0;
  logic [31:0] bp_addr = '0;
  logic [31:0] pc;
  logic        pc_run_en, pc_clr, bp_hit;
  logic [1:0]  state;
  logic [15:0] instr_cnt;

  int n_chk = 0;
  int n_err = 0;
  int tk, en_cnt, clr_cyc, overlap, first_en, seen_clear;

  mips_run_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .CLR_CYCLES     (4)
  ) dut (
    .clk_i      (clk),
    .rst_n      (rst_n),
    .btn_step_i (btn_step),
    .btn_run_i  (btn_run),
    .btn_clr_i  (btn_clr),
    .bp_en_i    (bp_en),
    .bp_addr_i  (bp_addr),
    .pc_i       (pc),
    .pc_run_en_o(pc_run_en),
    .pc_clr_o   (pc_clr),
    .state_o    (state),
    .bp_hit_o   (bp_hit),
    .instr_cnt_o(instr_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)         pc <= '0;
    else if (pc_clr)    pc <= '0;
    else if (pc_run_en) pc <= pc + 32'd4;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    tk = 0; en_cnt = 0; clr_cyc = 0; overlap = 0; first_en = -1; seen_clear = 0;
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tk++;
      if (pc_run_en) en_cnt++;
      if (pc_run_en && first_en < 0) first_en = tk;
      if (pc_clr) clr_cyc++;
      if (pc_clr && pc_run_en) overlap++;
      if (state == 2'b11) seen_clear = 1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    clear_stats();
    do_reset();
    check_eq("rst_state", state, 2'b00);
    check_eq("rst_run_en", pc_run_en, 0);
    check_eq("rst_clr", pc_clr, 0);
    check_eq("rst_bp_hit", bp_hit, 0);
    check_eq("rst_cnt", instr_cnt, 0);

    // 1: single held step press
    clear_stats();
    btn_step = 1'b1;
    tick(50);
    btn_step = 1'b0;
    tick(10);
    check_eq("step_pulses", en_cnt, 1);
    check_eq("step_latency", first_en, 7);
    check_eq("step_cnt", instr_cnt, 1);
    check_eq("step_state", state, 2'b00);

    // 2: bounce shorter than the debounce window
    do_reset();
    clear_stats();
    for (int i = 0; i < 5; i++) begin
      btn_step = 1'b1; tick(2);
      btn_step = 1'b0; tick(2);
    end
    tick(20);
    check_eq("bounce_en", en_cnt, 0);
    check_eq("bounce_cnt", instr_cnt, 0);

    // 3: run to breakpoint, then resume past it
    bp_en = 1'b1;
    bp_addr = 32'h0C;
    clear_stats();
    btn_run = 1'b1; tick(10);
    btn_run = 1'b0; tick(20);
    check_eq("bp_en_cycles", en_cnt, 3);
    check_eq("bp_pc", pc, 32'h0C);
    check_eq("bp_state", state, 2'b00);
    check_eq("bp_hit", bp_hit, 1);
    check_eq("bp_cnt", instr_cnt, 3);
    check_eq("bp_run_en_low", pc_run_en, 0);
    btn_run = 1'b1; tick(10);
    btn_run = 1'b0; tick(20);
    check_eq("resume_state", state, 2'b01);
    check_eq("resume_past_bp", pc > 32'h10, 1);
    check_eq("resume_bp_hit", bp_hit, 0);

    // 4: clear during run
    clear_stats();
    btn_clr = 1'b1; tick(10);
    btn_clr = 1'b0; tick(15);
    check_eq("clr_cycles", clr_cyc, 4);
    check_eq("clr_overlap", overlap, 0);
    check_eq("clr_seen", seen_clear, 1);
    check_eq("clr_state", state, 2'b00);
    check_eq("clr_cnt", instr_cnt, 0);
    check_eq("clr_pc", pc, 0);

    // clear also drops a sticky breakpoint hit
    btn_run = 1'b1; tick(10);
    btn_run = 1'b0; tick(15);
    check_eq("bp2_hit", bp_hit, 1);
    check_eq("bp2_cnt", instr_cnt, 3);
    btn_clr = 1'b1; tick(10);
    btn_clr = 1'b0; tick(15);
    check_eq("clr_bp_hit", bp_hit, 0);
    check_eq("clr2_cnt", instr_cnt, 0);

    // 5: coincident step and clr
    clear_stats();
    btn_step = 1'b1; btn_clr = 1'b1; tick(10);
    btn_step = 1'b0; btn_clr = 1'b0; tick(15);
    check_eq("coinc_en", en_cnt, 0);
    check_eq("coinc_clr", clr_cyc, 4);
    check_eq("coinc_state", state, 2'b00);

    // start/stop: press-to-press distance is 20 cycles
    bp_en = 1'b0;
    clear_stats();
    btn_run = 1'b1; tick(10);
    btn_run = 1'b0; tick(10);
    btn_run = 1'b1; tick(10);
    btn_run = 1'b0; tick(20);
    check_eq("toggle_en", en_cnt, 20);
    check_eq("toggle_cnt", instr_cnt, 20);
    check_eq("toggle_state", state, 2'b00);

    // 6: async reset mid-CLEAR
    btn_clr = 1'b1;
    for (int i = 0; i < 20 && !pc_clr; i++) tick(1);
    check_eq("mid_clr_reached", pc_clr, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_clr_clr", pc_clr, 0);
    check_eq("arst_clr_state", state, 2'b00);
    check_eq("arst_clr_cnt", instr_cnt, 0);
    btn_clr = 1'b0;
    tick(3);
    rst_n = 1'b1;
    clear_stats();
    tick(15);
    check_eq("post_rst_clr", clr_cyc, 0);
    check_eq("post_rst_en", en_cnt, 0);

    // async reset mid-RUN
    btn_run = 1'b1;
    for (int i = 0; i < 20 && !pc_run_en; i++) tick(1);
    check_eq("mid_run_reached", pc_run_en, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_run_en", pc_run_en, 0);
    check_eq("arst_run_state", state, 2'b00);
    check_eq("arst_run_cnt", instr_cnt, 0);
    btn_run = 1'b0;
    tick(3);
    rst_n = 1'b1;
    clear_stats();
    tick(15);
    check_eq("post_rst2_en", en_cnt, 0);
    check_eq("post_rst2_state", state, 2'b00);

    // counter wrap: halt after 65535 enabled cycles, then one step
    bp_en = 1'b1;
    bp_addr = 32'h3FFFC;
    clear_stats();
    btn_run = 1'b1; tick(10);
    btn_run = 1'b0;
    for (int i = 0; i < 70000 && state == 2'b01; i++) tick(1);
    check_eq("wrap_halt_state", state, 2'b00);
    check_eq("wrap_en", en_cnt, 65535);
    check_eq("wrap_pre_cnt", instr_cnt, 16'hFFFF);
    check_eq("wrap_bp_hit", bp_hit, 1);
    btn_step = 1'b1; tick(10);
    btn_step = 1'b0; tick(10);
    check_eq("wrap_cnt", instr_cnt, 16'h0000);
    check_eq("wrap_pc", pc, 32'h40000);
    check_eq("wrap_state", state, 2'b00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
